// File: rtl/mbc_shift_pkg.sv
// Shared mode encodings and FSM state type for the MBC shift register.
package mbc_shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_SRA  = 3'b100;
  localparam logic [2:0] MODE_ROTL = 3'b101;
  localparam logic [2:0] MODE_ROTR = 3'b110;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  // True for the modes that move bits and therefore produce a SER_OUT bit.
  function automatic logic is_step_mode(input logic [2:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_SRA) ||
           (mode == MODE_ROTL) || (mode == MODE_ROTR);
  endfunction

endpackage

// File: rtl/shift_reg_seq_step.sv
// Single-bit shift/rotate datapath, shared by the one-shot and RUN paths.
module shift_step_unit
  import mbc_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] q_o,
  output logic             out_o
);

  always_comb begin
    q_o   = q_i;
    out_o = 1'b0;
    case (mode_i)
      MODE_SHL: begin
        q_o   = {q_i[WIDTH-2:0], ser_i};
        out_o = q_i[WIDTH-1];
      end
      MODE_SHR: begin
        q_o   = {ser_i, q_i[WIDTH-1:1]};
        out_o = q_i[0];
      end
      MODE_SRA: begin
        q_o   = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        out_o = q_i[0];
      end
      MODE_ROTL: begin
        q_o   = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        out_o = q_i[WIDTH-1];
      end
      MODE_ROTR: begin
        q_o   = {q_i[0], q_i[WIDTH-1:1]};
        out_o = q_i[0];
      end
      default: begin
        q_o   = q_i;
        out_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_seq.sv
// Loadable shift/rotate register with a sequenced multi-step operation and
// BUSY/DONE handshake; all outputs registered.
module shift_reg_seq
  import mbc_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             CLOCK,
  input  logic             CLEAR,
  input  logic             ENABLE,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             SER_IN,
  input  logic             START,
  input  logic [CNT_W-1:0] AMOUNT,
  output logic [WIDTH-1:0] Q,
  output logic             SER_OUT,
  output logic             BUSY,
  output logic             DONE
);

  state_e           state_q;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_q;
  logic             ser_q;
  logic             busy_q;
  logic             done_q;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] shift_d;
  logic             shout_d;

  // In RUN the latched mode drives the datapath; live MODE is ignored.
  assign step_mode = (state_q == ST_RUN) ? mode_q : MODE;

  shift_step_unit #(.WIDTH(WIDTH)) u_step (
    .mode_i (step_mode),
    .q_i    (q_q),
    .ser_i  (SER_IN),
    .q_o    (shift_d),
    .out_o  (shout_d)
  );

  always_ff @(posedge CLOCK) begin
    done_q <= 1'b0;
    if (CLEAR) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (ENABLE) begin
      case (state_q)
        ST_IDLE: begin
          if (START && is_step_mode(MODE) && (AMOUNT != '0)) begin
            mode_q  <= MODE;
            cnt_q   <= AMOUNT;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            if (MODE == MODE_LOAD) begin
              q_q <= D_IN;
            end else if (is_step_mode(MODE)) begin
              q_q   <= shift_d;
              ser_q <= shout_d;
            end
            if (START) begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          q_q   <= shift_d;
          ser_q <= shout_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Q       = q_q;
  assign SER_OUT = ser_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule
